// File: rtl/hit_if.sv
// hit_if: button inputs and debounced hit-event outputs of hit_encoder
interface hit_if;
  logic [3:0] btn;
  logic       arm;
  logic       hit_valid;
  logic [1:0] hit_idx;
  logic       multi_press;
  logic [3:0] btn_db;
  modport master(output btn, arm, input hit_valid, hit_idx, multi_press, btn_db);
  modport slave(input btn, arm, output hit_valid, hit_idx, multi_press, btn_db);
endinterface

// File: rtl/hit_encoder.sv
// hit_encoder: synchronizes and debounces four mole buttons, emits one-cycle hit/multi-press events
module hit_encoder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CW = $clog2(DEBOUNCE_CYCLES)
) (
  input logic clk,
  input logic rst_n,
  hit_if.slave bus
);
  typedef enum logic {IDLE, WAIT_REL} state_t;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [3:0] s1_q, s2_q, btn_db_q, btn_db_d;
  logic [3:0][CW-1:0] cnt_q, cnt_d;
  state_t state_q, state_d;
  logic hit_valid_q, hit_valid_d, multi_press_q, multi_press_d;
  logic [1:0] hit_idx_q, hit_idx_d, enc;
  logic one_hot, any_db;
  always_comb begin
    cnt_d = cnt_q;
    btn_db_d = btn_db_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = (s2_q[i] == btn_db_q[i] || cnt_q[i] == CMAX) ? '0 : cnt_q[i] + CW'(1);
      btn_db_d[i] = (s2_q[i] != btn_db_q[i] && cnt_q[i] == CMAX) ? s2_q[i] : btn_db_q[i];
    end
  end
  // one_hot is true only for a single debounced button; anything more is a multi-press
  assign any_db = |btn_db_q;
  assign one_hot = any_db && ((btn_db_q & (btn_db_q - 4'd1)) == 4'd0);
  assign enc = btn_db_q[3] ? 2'd3 : btn_db_q[2] ? 2'd2 : btn_db_q[1] ? 2'd1 : 2'd0;
  always_comb begin
    state_d = state_q;
    hit_valid_d = 1'b0;
    multi_press_d = 1'b0;
    hit_idx_d = hit_idx_q;
    if (state_q == IDLE) begin
      state_d = any_db ? WAIT_REL : IDLE;
      hit_valid_d = any_db && bus.arm && one_hot;
      multi_press_d = any_db && bus.arm && !one_hot;
      hit_idx_d = (any_db && bus.arm && one_hot) ? enc : hit_idx_q;
    end else begin
      state_d = any_db ? WAIT_REL : IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      cnt_q <= '0;
      btn_db_q <= '0;
      state_q <= IDLE;
      hit_valid_q <= 1'b0;
      multi_press_q <= 1'b0;
      hit_idx_q <= 2'b00;
    end else begin
      s1_q <= bus.btn;
      s2_q <= s1_q;
      cnt_q <= cnt_d;
      btn_db_q <= btn_db_d;
      state_q <= state_d;
      hit_valid_q <= hit_valid_d;
      multi_press_q <= multi_press_d;
      hit_idx_q <= hit_idx_d;
    end
  end
  assign bus.hit_valid = hit_valid_q;
  assign bus.multi_press = multi_press_q;
  assign bus.hit_idx = hit_idx_q;
  assign bus.btn_db = btn_db_q;
endmodule

// File: tb/tb_hit_encoder.sv
// tb_hit_encoder: directed scenarios with a queue-based scoreboard for hit/multi-press events
module tb_hit_encoder;
  typedef struct {logic multi; logic [1:0] idx; int cyc;} ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  ev_t q[$];
  ev_t e;
  hit_if bus();
  hit_encoder #(.DEBOUNCE_CYCLES(4)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // A button driven at a negedge is first sampled on the next edge; its event shows 7 edges on
  task automatic expect_ev(input logic multi, input logic [1:0] idx, input int lat);
    q.push_back('{multi, idx, cyc + lat});
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (rst_n && (bus.hit_valid || bus.multi_press)) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event hv=%0b mp=%0b idx=%0d cyc=%0d", bus.hit_valid, bus.multi_press, bus.hit_idx, cyc);
      end else begin
        e = q.pop_front();
        if (bus.multi_press != e.multi || bus.hit_valid == bus.multi_press || bus.hit_idx != e.idx || cyc != e.cyc) begin
          failures++;
          $display("FAIL event got hv=%0b mp=%0b idx=%0d cyc=%0d expected mp=%0b idx=%0d cyc=%0d",
                   bus.hit_valid, bus.multi_press, bus.hit_idx, cyc, e.multi, e.idx, e.cyc);
        end
      end
    end
  end
  initial begin
    bus.btn = 4'b0000;
    bus.arm = 1'b0;
    cycles(3);
    chk("reset_hit_valid", int'(bus.hit_valid), 0);
    chk("reset_multi_press", int'(bus.multi_press), 0);
    chk("reset_hit_idx", int'(bus.hit_idx), 0);
    chk("reset_btn_db", int'(bus.btn_db), 0);
    rst_n = 1'b1;
    cycles(2);
    // simultaneous press
    bus.arm = 1'b1;
    bus.btn = 4'b1001;
    expect_ev(1'b1, 2'd0, 7);
    cycles(10);
    chk("multi_btn_db", int'(bus.btn_db), 4'b1001);
    chk("multi_idx_unchanged", int'(bus.hit_idx), 0);
    bus.btn = 4'b0000;
    cycles(12);
    chk("release_btn_db", int'(bus.btn_db), 0);
    // clean single press
    bus.btn = 4'b0100;
    expect_ev(1'b0, 2'd2, 7);
    cycles(20);
    chk("single_btn_db", int'(bus.btn_db), 4'b0100);
    chk("single_idx_hold", int'(bus.hit_idx), 2);
    bus.btn = 4'b0000;
    cycles(12);
    // bounce rejection
    for (int i = 0; i < 4; i++) begin
      bus.btn = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      cycles(1);
    end
    chk("bounce_btn_db", int'(bus.btn_db), 0);
    bus.btn = 4'b0010;
    expect_ev(1'b0, 2'd1, 7);
    cycles(15);
    chk("bounce_btn_db_held", int'(bus.btn_db), 4'b0010);
    bus.btn = 4'b0000;
    cycles(12);
    // staggered press then re-press
    bus.btn = 4'b1000;
    expect_ev(1'b0, 2'd3, 7);
    cycles(10);
    bus.btn = 4'b1001;
    cycles(10);
    chk("stagger_btn_db", int'(bus.btn_db), 4'b1001);
    bus.btn = 4'b0000;
    cycles(12);
    bus.btn = 4'b0001;
    expect_ev(1'b0, 2'd0, 7);
    cycles(10);
    bus.btn = 4'b0000;
    cycles(12);
    // disarmed press, arm raised while held
    bus.arm = 1'b0;
    bus.btn = 4'b0100;
    cycles(10);
    bus.arm = 1'b1;
    cycles(10);
    chk("disarm_btn_db", int'(bus.btn_db), 4'b0100);
    bus.btn = 4'b0000;
    cycles(12);
    bus.btn = 4'b0100;
    expect_ev(1'b0, 2'd2, 7);
    cycles(10);
    bus.btn = 4'b0000;
    cycles(12);
    // async reset while held in WAIT_REL
    bus.btn = 4'b0010;
    expect_ev(1'b0, 2'd1, 7);
    cycles(10);
    rst_n = 1'b0;
    #1;
    chk("areset_hit_valid", int'(bus.hit_valid), 0);
    chk("areset_multi_press", int'(bus.multi_press), 0);
    chk("areset_hit_idx", int'(bus.hit_idx), 0);
    chk("areset_btn_db", int'(bus.btn_db), 0);
    cycles(2);
    rst_n = 1'b1;
    expect_ev(1'b0, 2'd1, 7);
    cycles(12);
    chk("areset_btn_db_held", int'(bus.btn_db), 4'b0010);
    chk("missing_events", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
